core_sequencer: RTL and testbench

Multicycle control sequencer for the MUSA core. It steps each instruction through fetch, decode, execute, memory and writeback, and issues one-cycle write strobes to the instruction register, PC and register file. It handshakes instruction and data memory via `mem_ready` and owns the stack pointer used by push/pop. It sits beside the decode stage: it consumes that stage's instruction-class flags and gates the strobes the datapath acts on.

---
 rtl/core_sequencer_if.sv | 40 ++++
 rtl/core_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_core_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: groups the sequencer's handshake, decode-class and status
// signals into one bundle.
//   master : the sequencer side (drives strobes, stack address, status)
//   slave  : the core/memory side (drives run, mem_ready, decode classes)
interface core_sequencer_if;
  logic        run;
  logic        mem_ready;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_push;
  logic        dec_pop;
  logic        dec_reg_write;
  logic        dec_jump;
  logic        if_req;
  logic        ir_write;
  logic        pc_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [31:0] stack_addr;
  logic [31:0] sp;
  logic [2:0]  stage;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  modport master (
    input  run, mem_ready, dec_mem_read, dec_mem_write, dec_push, dec_pop,
           dec_reg_write, dec_jump,
    output if_req, ir_write, pc_write, mem_read, mem_write, reg_write,
           stack_addr, sp, stage, fault, fault_code, retired
  );

  modport slave (
    output run, mem_ready, dec_mem_read, dec_mem_write, dec_push, dec_pop,
           dec_reg_write, dec_jump,
    input  if_req, ir_write, pc_write, mem_read, mem_write, reg_write,
           stack_addr, sp, stage, fault, fault_code, retired
  );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
// for the MUSA core. It issues registered one-cycle write strobes, handshakes
// memory through mem_ready with a wait-cycle timeout, and owns the push/pop
// stack pointer.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : core_sequencer_if.master (run/mem_ready/decode classes in; strobes,
//         stack_addr, sp, stage, fault, fault_code, retired out)
module core_sequencer #(
  parameter logic [31:0] SP_RESET    = 32'h0000_03FC,
  parameter logic [31:0] SP_LIMIT    = 32'h0000_0200,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  core_sequencer_if.master bus
);

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic push;
    logic pop;
    logic rw;
    logic jump;
  } cls_t;

  state_t              r_state, w_next;
  cls_t                r_cls, w_cls_next, w_dec;
  logic [31:0]         r_sp, w_sp_next, r_retired, w_retired_next, w_sp_m4;
  logic [WAIT_W-1:0]   r_wait, w_wait_next;
  logic                r_fault, w_fault_next;
  logic [1:0]          r_fault_code, w_code_next;
  logic                r_if_req, r_ir_write, r_pc_write, r_mem_read, r_mem_write, r_reg_write;
  logic                w_if_req_next, w_ir_write_next, w_pc_write_next;
  logic                w_mem_read_next, w_mem_write_next, w_reg_write_next;
  logic                w_multi, w_ovf, w_timeout, w_retire;

  assign w_dec = {bus.dec_mem_read, bus.dec_mem_write, bus.dec_push, bus.dec_pop,
                  bus.dec_reg_write, bus.dec_jump};

  // More than one memory class in the same instruction is illegal.
  assign w_multi = (3'(w_dec.rd) + 3'(w_dec.wr) + 3'(w_dec.push) + 3'(w_dec.pop)) > 3'd1;

  // sp below 4 would wrap on the decrement, so it counts as overflow too.
  assign w_sp_m4   = r_sp - 32'd4;
  assign w_ovf     = (r_sp < 32'd4) || (w_sp_m4 < SP_LIMIT);
  assign w_timeout = (r_wait == WAIT_W'(MEM_TIMEOUT));

  // Next-state, datapath and next-strobe logic.
  always_comb begin
    w_next           = r_state;
    w_cls_next       = r_cls;
    w_sp_next        = r_sp;
    w_retired_next   = r_retired;
    w_wait_next      = r_wait;
    w_fault_next     = r_fault;
    w_code_next      = r_fault_code;
    w_retire         = 1'b0;
    w_ir_write_next  = 1'b0;
    w_pc_write_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_next      = S_FETCH;
          w_wait_next = '0;
        end
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_ir_write_next = 1'b1;
          w_pc_write_next = 1'b1;
          w_next          = S_DECODE;
        end else if (w_timeout) begin
          w_next      = S_FAULT;
          w_code_next = 2'd3;
        end else begin
          w_wait_next = r_wait + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        w_cls_next = w_dec;
        if (w_multi) begin
          w_next      = S_FAULT;
          w_code_next = 2'd0;
        end else if (w_dec.push && w_ovf) begin
          w_next      = S_FAULT;
          w_code_next = 2'd1;
        end else if (w_dec.pop && (r_sp == SP_RESET)) begin
          w_next      = S_FAULT;
          w_code_next = 2'd2;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (r_cls.jump) begin
          w_pc_write_next = 1'b1;
          w_retire        = 1'b1;
        end else if (r_cls.rd || r_cls.wr || r_cls.push || r_cls.pop) begin
          w_next      = S_MEMORY;
          w_wait_next = '0;
        end else if (r_cls.rw) begin
          w_next = S_WRITEBACK;
        end else begin
          w_retire = 1'b1;
        end
      end
      S_MEMORY: begin
        if (bus.mem_ready) begin
          if (r_cls.push) w_sp_next = w_sp_m4;
          if (r_cls.pop)  w_sp_next = r_sp + 32'd4;
          if (r_cls.rd || r_cls.pop) w_next = S_WRITEBACK;
          else                       w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next      = S_FAULT;
          w_code_next = 2'd3;
        end else begin
          w_wait_next = r_wait + WAIT_W'(1);
        end
      end
      S_WRITEBACK: w_retire = 1'b1;
      S_FAULT:     w_next   = S_FAULT;
      default:     w_next   = S_FAULT;
    endcase

    // Retirement returns to FETCH or, once run has dropped, parks in IDLE.
    if (w_retire) begin
      w_retired_next = r_retired + 32'd1;
      w_cls_next     = '0;
      w_wait_next    = '0;
      w_next         = bus.run ? S_FETCH : S_IDLE;
    end

    if (w_next == S_FAULT) w_fault_next = 1'b1;

    // Request strobes follow the state being entered so they are Moore outputs.
    w_if_req_next    = (w_next == S_FETCH);
    w_mem_read_next  = (w_next == S_MEMORY) && (w_cls_next.rd || w_cls_next.pop);
    w_mem_write_next = (w_next == S_MEMORY) && (w_cls_next.wr || w_cls_next.push);
    w_reg_write_next = (w_next == S_WRITEBACK);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cls        <= '0;
      r_sp         <= SP_RESET;
      r_retired    <= '0;
      r_wait       <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
      r_if_req     <= 1'b0;
      r_ir_write   <= 1'b0;
      r_pc_write   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cls        <= w_cls_next;
      r_sp         <= w_sp_next;
      r_retired    <= w_retired_next;
      r_wait       <= w_wait_next;
      r_fault      <= w_fault_next;
      r_fault_code <= w_code_next;
      r_if_req     <= w_if_req_next;
      r_ir_write   <= w_ir_write_next;
      r_pc_write   <= w_pc_write_next;
      r_mem_read   <= w_mem_read_next;
      r_mem_write  <= w_mem_write_next;
      r_reg_write  <= w_reg_write_next;
    end
  end

  // Stack address is combinational from the latched class and sp.
  assign bus.stack_addr = r_cls.push ? w_sp_m4 : (r_cls.pop ? r_sp : 32'd0);
  assign bus.sp         = r_sp;
  assign bus.stage      = r_state;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.retired    = r_retired;
  assign bus.if_req     = r_if_req;
  assign bus.ir_write   = r_ir_write;
  assign bus.pc_write   = r_pc_write;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.reg_write  = r_reg_write;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed checks of core_sequencer. Two instances share
// clock and reset; u_b uses SP_LIMIT=0x3FC so its first push must overflow.
module tb_core_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  core_sequencer_if bus_a ();
  core_sequencer_if bus_b ();

  core_sequencer u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  core_sequencer #(.SP_LIMIT(32'h0000_03FC)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    bus_a.run           = 1'b0;
    bus_a.mem_ready     = 1'b0;
    bus_a.dec_mem_read  = 1'b0;
    bus_a.dec_mem_write = 1'b0;
    bus_a.dec_push      = 1'b0;
    bus_a.dec_pop       = 1'b0;
    bus_a.dec_reg_write = 1'b0;
    bus_a.dec_jump      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_a();
    bus_b.run           = 1'b0;
    bus_b.mem_ready     = 1'b1;
    bus_b.dec_mem_read  = 1'b0;
    bus_b.dec_mem_write = 1'b0;
    bus_b.dec_push      = 1'b1;
    bus_b.dec_pop       = 1'b0;
    bus_b.dec_reg_write = 1'b0;
    bus_b.dec_jump      = 1'b0;
    rst = 1'b0;
    cyc(2);

    // Reset state
    chk("rst_stage",   32'(bus_a.stage),      32'd0);
    chk("rst_sp",      bus_a.sp,              32'h3FC);
    chk("rst_retired", bus_a.retired,         32'd0);
    chk("rst_fault",   32'(bus_a.fault),      32'd0);
    chk("rst_code",    32'(bus_a.fault_code), 32'd0);
    chk("rst_if_req",  32'(bus_a.if_req),     32'd0);
    chk("rst_saddr",   bus_a.stack_addr,      32'd0);
    rst = 1'b1;

    // ALU with writeback, zero-wait memory
    bus_a.dec_reg_write = 1'b1;
    bus_a.mem_ready     = 1'b1;
    bus_a.run           = 1'b1;
    bus_b.run           = 1'b1;
    chk("alu_c0_stage", 32'(bus_a.stage), 32'd0);
    cyc(1);
    chk("alu_c1_stage", 32'(bus_a.stage),    32'd1);
    chk("alu_c1_ifreq", 32'(bus_a.if_req),   32'd1);
    chk("alu_c1_irw",   32'(bus_a.ir_write), 32'd0);
    cyc(1);
    chk("alu_c2_stage", 32'(bus_a.stage),    32'd2);
    chk("alu_c2_irw",   32'(bus_a.ir_write), 32'd1);
    chk("alu_c2_pcw",   32'(bus_a.pc_write), 32'd1);
    chk("alu_c2_ifreq", 32'(bus_a.if_req),   32'd0);
    cyc(1);
    chk("alu_c3_stage", 32'(bus_a.stage),    32'd3);
    chk("alu_c3_irw",   32'(bus_a.ir_write), 32'd0);
    chk("lim_b_stage",  32'(bus_b.stage),      32'd6);
    chk("lim_b_code",   32'(bus_b.fault_code), 32'd1);
    chk("lim_b_fault",  32'(bus_b.fault),      32'd1);
    cyc(1);
    chk("alu_c4_stage", 32'(bus_a.stage),     32'd5);
    chk("alu_c4_regw",  32'(bus_a.reg_write), 32'd1);
    chk("alu_c4_ret",   bus_a.retired,        32'd0);
    bus_a.dec_reg_write = 1'b0;
    bus_a.dec_jump      = 1'b1;
    cyc(1);
    chk("alu_c5_stage", 32'(bus_a.stage),     32'd1);
    chk("alu_c5_regw",  32'(bus_a.reg_write), 32'd0);
    chk("alu_ret",      bus_a.retired,        32'd1);

    // Jump: FETCH, DECODE, EXECUTE, then a pc_write pulse
    cyc(2);
    chk("jmp_stage3",  32'(bus_a.stage),    32'd3);
    chk("jmp_pcw_ex",  32'(bus_a.pc_write), 32'd0);
    bus_a.dec_jump = 1'b0;
    bus_a.dec_push = 1'b1;
    cyc(1);
    chk("jmp_stage_f", 32'(bus_a.stage),    32'd1);
    chk("jmp_pcw",     32'(bus_a.pc_write), 32'd1);
    chk("jmp_ret",     bus_a.retired,       32'd2);

    // Push with mem_ready low for 3 MEMORY cycles
    cyc(1);
    chk("push_dec", 32'(bus_a.stage), 32'd2);
    bus_a.mem_ready = 1'b0;
    cyc(1);
    chk("push_ex_saddr", bus_a.stack_addr, 32'h3F8);
    cyc(1);
    chk("push_m1_stage", 32'(bus_a.stage),     32'd4);
    chk("push_m1_wr",    32'(bus_a.mem_write), 32'd1);
    chk("push_m1_rd",    32'(bus_a.mem_read),  32'd0);
    cyc(1);
    chk("push_m2_wr",    32'(bus_a.mem_write), 32'd1);
    cyc(1);
    chk("push_m3_wr",    32'(bus_a.mem_write), 32'd1);
    cyc(1);
    chk("push_m4_wr",    32'(bus_a.mem_write), 32'd1);
    chk("push_m4_saddr", bus_a.stack_addr,     32'h3F8);
    chk("push_m4_sp",    bus_a.sp,             32'h3FC);
    bus_a.mem_ready = 1'b1;
    bus_a.dec_push  = 1'b0;
    bus_a.dec_pop   = 1'b1;
    cyc(1);
    chk("push_sp",    bus_a.sp,             32'h3F8);
    chk("push_wr_lo", 32'(bus_a.mem_write), 32'd0);
    chk("push_ret",   bus_a.retired,        32'd3);
    chk("push_stage", 32'(bus_a.stage),     32'd1);

    // Pop back to the empty-stack address
    cyc(2);
    chk("pop_ex_saddr", bus_a.stack_addr, 32'h3F8);
    cyc(1);
    chk("pop_m_rd",    32'(bus_a.mem_read),  32'd1);
    chk("pop_m_saddr", bus_a.stack_addr,     32'h3F8);
    cyc(1);
    chk("pop_wb_stage", 32'(bus_a.stage),     32'd5);
    chk("pop_wb_regw",  32'(bus_a.reg_write), 32'd1);
    chk("pop_sp",       bus_a.sp,             32'h3FC);
    chk("pop_rd_lo",    32'(bus_a.mem_read),  32'd0);
    cyc(1);
    chk("pop_regw_lo",  32'(bus_a.reg_write), 32'd0);
    chk("pop_ret",      bus_a.retired,        32'd4);

    // Pop on an empty stack faults before any data access
    clear_a();
    do_reset();
    bus_a.run       = 1'b1;
    bus_a.mem_ready = 1'b1;
    bus_a.dec_pop   = 1'b1;
    cyc(3);
    chk("unf_stage", 32'(bus_a.stage),      32'd6);
    chk("unf_code",  32'(bus_a.fault_code), 32'd2);
    chk("unf_fault", 32'(bus_a.fault),      32'd1);
    cyc(1);
    chk("unf_rd",    32'(bus_a.mem_read),   32'd0);
    chk("unf_stay",  32'(bus_a.stage),      32'd6);

    // Push and pop together is an illegal class
    clear_a();
    do_reset();
    bus_a.run       = 1'b1;
    bus_a.mem_ready = 1'b1;
    bus_a.dec_push  = 1'b1;
    bus_a.dec_pop   = 1'b1;
    cyc(3);
    chk("ill_stage", 32'(bus_a.stage),      32'd6);
    chk("ill_code",  32'(bus_a.fault_code), 32'd0);

    // Fetch timeout: 15 wait cycles tolerated, the 16th faults
    clear_a();
    do_reset();
    chk("rst_fault_clr", 32'(bus_a.fault), 32'd0);
    bus_a.run = 1'b1;
    cyc(16);
    chk("to_stage16",  32'(bus_a.stage),  32'd1);
    chk("to_ifreq16",  32'(bus_a.if_req), 32'd1);
    cyc(1);
    chk("to_stage",    32'(bus_a.stage),      32'd6);
    chk("to_code",     32'(bus_a.fault_code), 32'd3);
    chk("to_ifreq",    32'(bus_a.if_req),     32'd0);

    // run drops during a load's MEMORY stage: load finishes, then IDLE
    clear_a();
    do_reset();
    bus_a.run          = 1'b1;
    bus_a.mem_ready    = 1'b1;
    bus_a.dec_mem_read = 1'b1;
    cyc(4);
    chk("ld_m_stage", 32'(bus_a.stage),    32'd4);
    chk("ld_m_rd",    32'(bus_a.mem_read), 32'd1);
    bus_a.run = 1'b0;
    cyc(1);
    chk("ld_wb_regw", 32'(bus_a.reg_write), 32'd1);
    cyc(1);
    chk("ld_idle",    32'(bus_a.stage),  32'd0);
    chk("ld_ret",     bus_a.retired,     32'd1);
    chk("ld_ifreq",   32'(bus_a.if_req), 32'd0);

    // Push, then asynchronous reset in the middle of a load's WRITEBACK
    bus_a.run          = 1'b1;
    bus_a.dec_mem_read = 1'b0;
    bus_a.dec_push     = 1'b1;
    cyc(5);
    chk("rp_sp",   bus_a.sp,         32'h3F8);
    bus_a.dec_push     = 1'b0;
    bus_a.dec_mem_read = 1'b1;
    cyc(4);
    chk("rp_wb_regw", 32'(bus_a.reg_write), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_stage", 32'(bus_a.stage),     32'd0);
    chk("ar_regw",  32'(bus_a.reg_write), 32'd0);
    chk("ar_sp",    bus_a.sp,             32'h3FC);
    chk("ar_ret",   bus_a.retired,        32'd0);
    cyc(1);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
